// File: rtl/hero_pkg.sv
// Shared definitions for the player/enemy character controllers.
// Latency: n/a (types, constants and pure helper functions only).
// Backpressure: n/a.
//
// Contents: facing codes, controller state encoding, collision bit
// indices (shared with the collision detector) and small integer helpers
// used by the position and attack-box datapaths.
package hero_pkg;

    // Facing codes as presented on the facing output.
    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_e;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ATTACK = 1'b1
    } state_e;

    // Bit positions inside the 4-bit collision vector.
    localparam int COL_UP    = 3;
    localparam int COL_DOWN  = 2;
    localparam int COL_RIGHT = 1;
    localparam int COL_LEFT  = 0;

    // Step down towards a lower bound without ever going below it; the
    // comparison is done first so an unsigned coordinate never wraps.
    function automatic int step_dec(input int v, input int step, input int lo);
        return (v >= lo + step) ? v - step : lo;
    endfunction

    // Step up towards an upper bound, saturating at it.
    function automatic int step_inc(input int v, input int step, input int hi);
        return (v + step <= hi) ? v + step : hi;
    endfunction

    // Attack boxes may hang off the top/left of the screen; clamp to 0.
    function automatic int clamp0(input int v);
        return (v < 0) ? 0 : v;
    endfunction

endpackage

// File: rtl/character_ctl_if.sv
// Bundle of button inputs and sprite/attack outputs of character_ctl.
// Latency: n/a (wiring only).
// Backpressure: none; all signals are plain levels.
//
// master: button/collision source side (drives inputs, observes outputs)
// slave : the character controller itself
interface character_ctl_if #(
    parameter int POS_W = 12
);
    logic             up;
    logic             down;
    logic             left;
    logic             right;
    logic             center;
    logic             freeze;
    logic [3:0]       collision;
    logic [POS_W-1:0] x_pos;
    logic [POS_W-1:0] y_pos;
    logic [1:0]       facing;
    logic             attack_active;
    logic [POS_W-1:0] atk_x;
    logic [POS_W-1:0] atk_y;
    logic [POS_W-1:0] atk_w;
    logic [POS_W-1:0] atk_h;

    modport master (
        output up, down, left, right, center, freeze, collision,
        input  x_pos, y_pos, facing, attack_active, atk_x, atk_y, atk_w, atk_h
    );

    modport slave (
        input  up, down, left, right, center, freeze, collision,
        output x_pos, y_pos, facing, attack_active, atk_x, atk_y, atk_w, atk_h
    );
endinterface

// File: rtl/tick_gen.sv
// Free-running divider producing a one-cycle tick every DIV enabled cycles.
// Latency: tick is combinational from the counter (asserted while count == DIV-1).
// Backpressure: en=0 holds the count and forces tick low.
//
// Ports: clk, rst (async, active-high), en (count enable), tick (strobe).
module tick_gen #(
    parameter int DIV = 100000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] r_cnt;

    assign tick = en && (r_cnt == CW'(DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= tick ? '0 : r_cnt + 1'b1;
        end
    end
endmodule

// File: rtl/character_ctl.sv
// Player-character movement/attack controller stepped by an internal move tick.
// Latency: all outputs registered; decisions on a tick cycle show one clk later.
// Backpressure: none; freeze stalls the tick (and so all state changes).
//
// Ports: clk, rst (async, active-high), bus (character_ctl_if.slave):
//   buttons up/down/left/right/center, freeze, collision[3:0] in;
//   x_pos/y_pos, facing, attack_active, atk_x/atk_y/atk_w/atk_h out.
module character_ctl
    import hero_pkg::*;
#(
    parameter int POS_W     = 12,
    parameter int X_MIN     = 62,
    parameter int X_MAX     = 962,
    parameter int Y_MIN     = 108,
    parameter int Y_MAX     = 708,
    parameter int START_X   = 481,
    parameter int START_Y   = 648,
    parameter int SPRITE_W  = 60,
    parameter int SPRITE_H  = 60,
    parameter int STEP      = 1,
    parameter int MOVE_DIV  = 100000,
    parameter int ATK_REACH = 40,
    parameter int ATK_SPAN  = 20,
    parameter int ATK_TICKS = 10
) (
    input  logic            clk,
    input  logic            rst,
    character_ctl_if.slave  bus
);
    if (STEP < 1 || STEP > 15) begin : g_bad_step
        $error("character_ctl: STEP must be in 1..15");
    end
    if (MOVE_DIV < 2) begin : g_bad_div
        $error("character_ctl: MOVE_DIV must be >= 2");
    end

    // Offsets that centre the attack box along the sprite edge.
    localparam int HOFF  = (SPRITE_W - ATK_SPAN) / 2;
    localparam int VOFF  = (SPRITE_H - ATK_SPAN) / 2;
    localparam int X_HI  = X_MAX - SPRITE_W;
    localparam int Y_HI  = Y_MAX - SPRITE_H;
    // Counter holds ATK_TICKS-1 down to 0.
    localparam int CNT_W = (ATK_TICKS > 1) ? $clog2(ATK_TICKS) : 1;

    logic w_tick;

    tick_gen #(
        .DIV (MOVE_DIV)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .en   (!bus.freeze),
        .tick (w_tick)
    );

    state_e           r_state,  w_state;
    dir_e             r_facing, w_facing;
    logic [POS_W-1:0] r_x,      w_x;
    logic [POS_W-1:0] r_y,      w_y;
    logic             r_active, w_active;
    logic             r_armed,  w_armed;
    logic [CNT_W-1:0] r_cnt,    w_cnt;
    logic [POS_W-1:0] r_atk_x,  w_atk_x;
    logic [POS_W-1:0] r_atk_y,  w_atk_y;
    logic [POS_W-1:0] r_atk_w,  w_atk_w;
    logic [POS_W-1:0] r_atk_h,  w_atk_h;

    int w_xi;
    int w_yi;

    assign w_xi = int'(r_x);
    assign w_yi = int'(r_y);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_facing <= DIR_UP;
            r_x      <= POS_W'(START_X);
            r_y      <= POS_W'(START_Y);
            r_active <= 1'b0;
            r_armed  <= 1'b1;
            r_cnt    <= '0;
            r_atk_x  <= '0;
            r_atk_y  <= '0;
            r_atk_w  <= '0;
            r_atk_h  <= '0;
        end else begin
            r_state  <= w_state;
            r_facing <= w_facing;
            r_x      <= w_x;
            r_y      <= w_y;
            r_active <= w_active;
            r_armed  <= w_armed;
            r_cnt    <= w_cnt;
            r_atk_x  <= w_atk_x;
            r_atk_y  <= w_atk_y;
            r_atk_w  <= w_atk_w;
            r_atk_h  <= w_atk_h;
        end
    end

    always_comb begin
        w_state  = r_state;
        w_facing = r_facing;
        w_x      = r_x;
        w_y      = r_y;
        w_active = r_active;
        w_armed  = r_armed;
        w_cnt    = r_cnt;
        w_atk_x  = r_atk_x;
        w_atk_y  = r_atk_y;
        w_atk_w  = r_atk_w;
        w_atk_h  = r_atk_h;

        if (w_tick) begin
            // Re-arm on any released-center sample so a held button cannot
            // chain attacks; an attack start below overrides this.
            if (!bus.center) begin
                w_armed = 1'b1;
            end

            unique case (r_state)
                ST_IDLE: begin
                    if (bus.up) begin
                        w_facing = DIR_UP;
                        if (!bus.collision[COL_UP]) begin
                            w_y = POS_W'(step_dec(w_yi, STEP, Y_MIN));
                        end
                    end else if (bus.left) begin
                        w_facing = DIR_LEFT;
                        if (!bus.collision[COL_LEFT]) begin
                            w_x = POS_W'(step_dec(w_xi, STEP, X_MIN));
                        end
                    end else if (bus.right) begin
                        w_facing = DIR_RIGHT;
                        if (!bus.collision[COL_RIGHT]) begin
                            w_x = POS_W'(step_inc(w_xi, STEP, X_HI));
                        end
                    end else if (bus.down) begin
                        w_facing = DIR_DOWN;
                        if (!bus.collision[COL_DOWN]) begin
                            w_y = POS_W'(step_inc(w_yi, STEP, Y_HI));
                        end
                    end else if (bus.center && r_armed) begin
                        w_state  = ST_ATTACK;
                        w_active = 1'b1;
                        w_armed  = 1'b0;
                        w_cnt    = CNT_W'(ATK_TICKS - 1);
                        unique case (r_facing)
                            DIR_UP: begin
                                w_atk_x = POS_W'(clamp0(w_xi + HOFF));
                                w_atk_y = POS_W'(clamp0(w_yi - ATK_REACH));
                                w_atk_w = POS_W'(ATK_SPAN);
                                w_atk_h = POS_W'(ATK_REACH);
                            end
                            DIR_DOWN: begin
                                w_atk_x = POS_W'(clamp0(w_xi + HOFF));
                                w_atk_y = POS_W'(clamp0(w_yi + SPRITE_H));
                                w_atk_w = POS_W'(ATK_SPAN);
                                w_atk_h = POS_W'(ATK_REACH);
                            end
                            DIR_LEFT: begin
                                w_atk_x = POS_W'(clamp0(w_xi - ATK_REACH));
                                w_atk_y = POS_W'(clamp0(w_yi + VOFF));
                                w_atk_w = POS_W'(ATK_REACH);
                                w_atk_h = POS_W'(ATK_SPAN);
                            end
                            DIR_RIGHT: begin
                                w_atk_x = POS_W'(clamp0(w_xi + SPRITE_W));
                                w_atk_y = POS_W'(clamp0(w_yi + VOFF));
                                w_atk_w = POS_W'(ATK_REACH);
                                w_atk_h = POS_W'(ATK_SPAN);
                            end
                            default: ;
                        endcase
                    end
                end

                ST_ATTACK: begin
                    // Position and facing are frozen; only the timer runs.
                    if (r_cnt == '0) begin
                        w_state  = ST_IDLE;
                        w_active = 1'b0;
                        w_atk_x  = '0;
                        w_atk_y  = '0;
                        w_atk_w  = '0;
                        w_atk_h  = '0;
                    end else begin
                        w_cnt = r_cnt - 1'b1;
                    end
                end

                default: w_state = ST_IDLE;
            endcase
        end
    end

    assign bus.x_pos         = r_x;
    assign bus.y_pos         = r_y;
    assign bus.facing        = r_facing;
    assign bus.attack_active = r_active;
    assign bus.atk_x         = r_atk_x;
    assign bus.atk_y         = r_atk_y;
    assign bus.atk_w         = r_atk_w;
    assign bus.atk_h         = r_atk_h;
endmodule
